// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and MEM-stage ports onto one single-ported RAM.
// Generates the one-cycle ihit/dhit handshakes. Data wins ties unless it also won the previous grant.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              ihit,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dhit,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_load,
    input  logic              ram_ready
);

    typedef enum logic [2:0] {IDLE, IACC, DACC, IRESP, DRESP} state_t;

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    state_t            state, next_state;
    logic              last_d;
    logic              wen_q;
    logic [ADDR_W-1:0] iaddr_q, daddr_q;
    logic [DATA_W-1:0] dstore_q;
    logic              grant_d;

    // A data request loses to a pending fetch only right after its own grant.
    assign grant_d = (dREN | dWEN) & (~iREN | ~last_d);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    next_state = DACC;
                end else if (iREN) begin
                    next_state = IACC;
                end
            end
            DACC: begin
                if (ram_ready) next_state = DRESP;
            end
            IACC: begin
                // A dropped iREN still lets the RAM access finish; only the response is suppressed.
                if (ram_ready) next_state = iREN ? IRESP : IDLE;
            end
            IRESP:   next_state = IDLE;
            DRESP:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_d   <= 1'b0;
            wen_q    <= 1'b0;
            iaddr_q  <= '0;
            daddr_q  <= '0;
            dstore_q <= '0;
            iload    <= '0;
            dload    <= '0;
        end else begin
            if (state == IDLE) begin
                if (grant_d) begin
                    daddr_q  <= daddr & WORD_MASK;
                    dstore_q <= dstore;
                    wen_q    <= dWEN;
                    last_d   <= 1'b1;
                end else if (iREN) begin
                    iaddr_q <= iaddr & WORD_MASK;
                    last_d  <= 1'b0;
                end
            end
            if (state == DACC && ram_ready && !wen_q) begin
                dload <= ram_load;
            end
            if (state == IACC && ram_ready && iREN) begin
                iload <= ram_load;
            end
        end
    end

    always_comb begin
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;
        ihit      = 1'b0;
        dhit      = 1'b0;
        case (state)
            IACC: begin
                ram_ren  = 1'b1;
                ram_addr = iaddr_q;
            end
            DACC: begin
                ram_wen   = wen_q;
                ram_ren   = ~wen_q;
                ram_addr  = daddr_q;
                ram_store = dstore_q;
            end
            IRESP:   ihit = 1'b1;
            DRESP:   dhit = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases plus randomized request mixes.
// Expectations come from a transaction-level arbitration model and a reference memory.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic [31:0] iload, dload;
    logic        ihit, dhit;
    logic        ram_ren, ram_wen;
    logic [31:0] ram_addr, ram_store, ram_load;
    logic        ram_ready;

    int          cyc = 0;
    int          wait_w = 0;
    int          cnt;
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    int          tests = 0;
    int          fails = 0;
    bit          last_d_ref;
    logic [31:0] exp_iload, exp_dload;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dhit(dhit),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // RAM model: ready after wait_w extra strobe cycles, write committed on the ready edge
    assign ram_ready = (ram_ren | ram_wen) && (cnt == wait_w);
    assign ram_load  = mem[ram_addr[9:2]];

    always @(posedge CLK or posedge RST) begin
        if (RST) cnt <= 0;
        else if ((ram_ren | ram_wen) && !ram_ready) cnt <= cnt + 1;
        else cnt <= 0;
    end

    always @(posedge CLK) begin
        if (ram_wen && ram_ready) mem[ram_addr[9:2]] <= ram_store;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Presents the requests from an IDLE cycle and checks each predicted service in order.
    task automatic run_seq(input bit wi, input bit wdr, input bit wdw, input bit hold,
                           input int n_serv, input int w);
        bit kinds[$];
        bit pi, pd, ld, wr;
        int exp_cyc;
        pi = wi;
        pd = wdr | wdw;
        ld = last_d_ref;
        wr = wdw;
        for (int k = 0; k < n_serv; k++) begin
            if (pd && (!pi || !ld)) begin
                kinds.push_back(1'b1);
                ld = 1'b1;
                if (!hold) pd = 1'b0;
            end else if (pi) begin
                kinds.push_back(1'b0);
                ld = 1'b0;
                if (!hold) pi = 1'b0;
            end
        end
        wait_w  = w;
        iREN    = wi;
        dREN    = wdr;
        dWEN    = wdw;
        exp_cyc = cyc + 2 + w;
        while (kinds.size() > 0) begin
            @(posedge CLK); #1;
            if (ihit && dhit) check("dual_hit", 32'(ihit & dhit), 32'd0);
            if (ram_ren | ram_wen) begin
                if (kinds[0]) begin
                    check("d_ram_wen", 32'(ram_wen), 32'(wr));
                    check("d_ram_ren", 32'(ram_ren), 32'(!wr));
                    check("d_ram_addr", ram_addr, daddr & ~32'd3);
                    if (wr) check("d_ram_store", ram_store, dstore);
                end else begin
                    check("i_ram_ren", 32'(ram_ren), 32'd1);
                    check("i_ram_wen", 32'(ram_wen), 32'd0);
                    check("i_ram_addr", ram_addr, iaddr & ~32'd3);
                end
            end
            if (ihit | dhit) begin
                check("hit_kind", 32'(dhit), 32'(kinds[0]));
                check("hit_cycle", 32'(cyc), 32'(exp_cyc));
                if (kinds[0]) begin
                    if (wr) ref_mem[daddr[9:2]] = dstore;
                    else exp_dload = ref_mem[daddr[9:2]];
                    check("dload", dload, exp_dload);
                    last_d_ref = 1'b1;
                    if (!hold) begin dREN = 1'b0; dWEN = 1'b0; end
                end else begin
                    exp_iload = ref_mem[iaddr[9:2]];
                    check("iload", iload, exp_iload);
                    last_d_ref = 1'b0;
                    if (!hold) iREN = 1'b0;
                end
                void'(kinds.pop_front());
                exp_cyc = cyc + 3 + w;
                if (kinds.size() == 0) begin iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; end
            end else if (cyc >= exp_cyc) begin
                check("hit_timeout", 32'(cyc), 32'(exp_cyc - 1));
                kinds.delete();
            end
        end
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        @(posedge CLK); #1;
        check("hit_one_cycle", {30'd0, ihit, dhit}, 32'd0);
    endtask

    initial begin
        int rdy, ih, kind;
        bit wi;
        RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        last_d_ref = 1'b0; exp_iload = '0; exp_dload = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        repeat (2) @(posedge CLK);
        #1;
        check("rst_hits", {30'd0, ihit, dhit}, 32'd0);
        check("rst_strobes", {30'd0, ram_ren, ram_wen}, 32'd0);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_ram_store", ram_store, 32'd0);
        check("rst_iload", iload, 32'd0);
        check("rst_dload", dload, 32'd0);
        RST = 1'b0;
        @(posedge CLK); #1;

        // single fetch, ready in first ACC cycle
        iaddr = 32'h0000_0047;
        mem[8'h11] = 32'h8C22_0004;
        ref_mem[8'h11] = 32'h8C22_0004;
        run_seq(1'b1, 1'b0, 1'b0, 1'b0, 1, 0);
        check("fetch_word", iload, 32'h8C22_0004);

        // all three held: write, fetch, write again
        iaddr = $urandom; daddr = $urandom; dstore = $urandom;
        run_seq(1'b1, 1'b1, 1'b1, 1'b1, 3, 1);

        // write then read back the same word
        daddr = 32'h0000_0100; dstore = 32'hDEAD_BEEF;
        run_seq(1'b0, 1'b0, 1'b1, 1'b0, 1, 0);
        run_seq(1'b0, 1'b1, 1'b0, 1'b0, 1, 2);
        check("wr_rd_word", dload, 32'hDEAD_BEEF);

        // flush: iREN dropped in the second IACC cycle
        iaddr = 32'h0000_0204; wait_w = 3; iREN = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        iREN = 1'b0;
        rdy = (ram_ready ? 1 : 0); ih = 0;
        repeat (6) begin
            @(posedge CLK); #1;
            if (ram_ready) rdy++;
            if (ihit) ih++;
        end
        last_d_ref = 1'b0;
        check("flush_ram_done", 32'(rdy), 32'd1);
        check("flush_no_ihit", 32'(ih), 32'd0);
        check("flush_iload", iload, exp_iload);
        check("flush_idle", {30'd0, ram_ren, ram_wen}, 32'd0);
        daddr = 32'h0000_0300;
        run_seq(1'b0, 1'b1, 1'b0, 1'b0, 1, 1);

        for (int n = 0; n < 40; n++) begin
            wi = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 3);
            if (!wi && kind == 0) wi = 1'b1;
            iaddr = $urandom; daddr = $urandom; dstore = $urandom;
            if (n % 4 == 0) daddr = iaddr;
            run_seq(wi, kind == 1 || kind == 3, kind >= 2, 1'b0,
                    (wi ? 1 : 0) + (kind != 0 ? 1 : 0), $urandom_range(0, 3));
        end

        // reset in the middle of a data write
        daddr = 32'h0000_0040; dstore = 32'h1234_5678; wait_w = 6; dWEN = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("pre_rst_wen", 32'(ram_wen), 32'd1);
        #2 RST = 1'b1;
        #1;
        check("midrst_strobes", {30'd0, ram_ren, ram_wen}, 32'd0);
        check("midrst_hits", {30'd0, ihit, dhit}, 32'd0);
        check("midrst_addr", ram_addr, 32'd0);
        check("midrst_loads", iload | dload, 32'd0);
        dWEN = 1'b0;
        last_d_ref = 1'b0; exp_iload = '0; exp_dload = '0;
        @(posedge CLK); #1;
        RST = 1'b0;
        ih = 0;
        repeat (4) begin
            @(posedge CLK); #1;
            if (dhit || ram_wen || ram_ren) ih++;
        end
        check("post_rst_quiet", 32'(ih), 32'd0);
        check("post_rst_mem", mem[8'h10], ref_mem[8'h10]);
        iaddr = 32'h0000_0010; daddr = 32'h0000_0040;
        run_seq(1'b1, 1'b1, 1'b0, 1'b0, 2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Memory-side responder that generates the `ihit`/`dhit` handshakes consumed by the pipeline latches. Arbitrates the fetch-stage instruction port and the MEM-stage data port onto one shared single-ported RAM. Registers the returned word and pulses the matching hit for exactly one cycle. Data requests win ties, with a one-shot fairness rule so fetch cannot starve.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, word width

Clock and reset are one clock, `CLK`, and `RST`. Reset is asynchronous and active-high.

Ports:
- `CLK`  in  1  system clock, rising edge
- `RST`  in  1  asynchronous, active-high reset
- `iREN`  in  1  instruction read request; level, held until `ihit` or dropped on flush
- `iaddr`  in  ADDR_W  instruction byte address
- `iload`  out  DATA_W  instruction word, valid while `ihit`=1, held afterwards
- `ihit`  out  1  one-cycle instruction response pulse
- `dREN`  in  1  data read request; level, held until `dhit`
- `dWEN`  in  1  data write request; level, held until `dhit`
- `daddr`  in  ADDR_W  data byte address
- `dstore`  in  DATA_W  write data
- `dload`  out  DATA_W  read word, valid while `dhit`=1, held afterwards
- `dhit`  out  1  one-cycle data response pulse
- `ram_ren`  out  1  RAM read strobe
- `ram_wen`  out  1  RAM write strobe
- `ram_addr`  out  ADDR_W  RAM word address; bits [1:0] forced to 0
- `ram_store`  out  DATA_W  RAM write data
- `ram_load`  in  DATA_W  RAM read data, valid with `ram_ready`
- `ram_ready`  in  1  RAM access complete; may be high in the first access cycle

## Operation
- Reset values: all outputs 0, state IDLE, `last_d`=0.
- States: IDLE, IACC, DACC, IRESP, DRESP.
- **IDLE grant rules:**
  - `dREN|dWEN` and (`!iREN` | `!last_d`) -> DACC. Latch `daddr`, `dstore` and `dWEN` into the request registers.
  - Otherwise, if `iREN` -> IACC. Latch `iaddr`.
  - Otherwise stay in IDLE.
- `last_d` is set on entering DACC and cleared on entering IACC. A data request that competes with a pending fetch is therefore granted at most once in a row.
- `dREN` and `dWEN` both high -> treated as a write.
- **DACC:**
  - Drive `ram_wen`=latched wen and `ram_ren`=!latched wen.
  - Drive `ram_addr` and `ram_store` from the latches.
  - On `ram_ready` -> DRESP. `dload` <= `ram_load` on reads; unchanged on writes.
- **IACC:**
  - Drive `ram_ren`=1 and `ram_addr` from the latch.
  - On `ram_ready`: if `iREN` is still 1 -> IRESP with `iload` <= `ram_load`.
  - If `iREN` has dropped (flush) -> IDLE. The word is discarded, no `ihit`, `iload` unchanged.
- `iREN` dropping during IACC never aborts the RAM access. It only suppresses the response.
- **DRESP:** `dhit`=1 -> IDLE. **IRESP:** `ihit`=1 -> IDLE.
- No RAM strobes are driven in IDLE, IRESP or DRESP. The requester sees its hit before any re-arbitration, so a held request is never serviced twice.
- `RST` mid-access: RAM strobes, `ihit` and `dhit` drop asynchronously. The in-flight access is abandoned.

## Timing
- Request latency, from IDLE sample to hit, is 2 + W cycles, where W = RAM wait cycles before `ram_ready`. The minimum is 2 (hit at edge 2 when `ram_ready` is high in the first ACC cycle).
- RAM strobes are registered from the FSM. They never depend combinationally on `iREN`, `dREN` or `dWEN`.
- `ihit` and `dhit` are never high in the same cycle. Each is high for exactly one cycle per serviced request.
- Back-to-back throughput is one access per 3 + W cycles (ACC, RESP, IDLE).

## Test plan
- **Reset:** assert `RST` mid-DACC with `ram_wen`=1 -> all outputs 0 immediately, state IDLE after release, no `dhit`.
- **Single fetch:** `iREN`=1, `iaddr`=0x00000047, `ram_ready` high on the first ACC cycle, `ram_load`=0x8C220004 -> `ram_addr`=0x00000044, `ihit` at edge 2, `iload`=0x8C220004.
- **Arbitration and fairness:** `iREN`, `dREN` and `dWEN` all held from cycle 0, W=1. Expected order:
  - data write first, with `ram_wen`=1 and `ram_ren`=0;
  - then the fetch;
  - then data again.
  - `dhit` and `ihit` alternate, never coincident.
- **Flush discard:** `iREN`=1, W=3, drop `iREN` in the second IACC cycle -> RAM access completes, no `ihit`, `iload` keeps its prior value, state IDLE.
- **Write then read:** `dWEN`=1, `daddr`=0x100, `dstore`=0xDEADBEEF; then `dREN`=1, `daddr`=0x100 against a RAM model -> `ram_store`=0xDEADBEEF on the write, `dload`=0xDEADBEEF with the second `dhit`, `dload` unchanged by the write.
